rd_data_check: RTL
==================

# rd_data_check

Single-clock read-side checker that drains 16-bit words from the prefetch read FIFO (first-word-fall-through: `rd_vld` means `rd_data` is valid, `rd_en` pops) and compares them against an incrementing reference pattern. It sits directly downstream of the read FIFO in the `rd_clk` domain. It verifies one frame of DDR3 read-back per `start`, then reports `done`, a sticky `err_flag` and an error count.

## Interface
- `DATA_WIDTH`, 16, word width; must match the FIFO read width.
- `FRAME_LEN`, 8192, words checked per frame; legal range 2..65536.
- `CNT_W`, 16, width of `err_cnt`.

Ports:
- `rd_clk`  in  1  clock; the FIFO read clock.
- `rd_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to check one frame; sampled only in IDLE.
- `seed`  in  DATA_WIDTH  expected value of word 0; latched on accepted `start`.
- `rd_vld`  in  1  FIFO output word valid.
- `rd_data`  in  DATA_WIDTH  FIFO output word.
- `rd_en`  out  1  FIFO pop; combinational.
- `busy`  out  1  high in READ.
- `done`  out  1  one-cycle pulse when the frame completes.
- `err_flag`  out  1  sticky mismatch flag for the current or last frame.
- `err_cnt`  out  CNT_W  mismatch count, saturating.

## Operation
- States: IDLE, READ, DONE.
  - IDLE -> READ on `start`. On that edge: `exp <= seed`, `idx <= 0`, `err_flag <= 0`, `err_cnt <= 0`.
  - READ: `rd_en = rd_vld`. Each pop compares `rd_data` with `exp`, then `exp <= exp + 1` (wraps mod 2^DATA_WIDTH) and `idx <= idx + 1`.
  - READ -> DONE on the pop with `idx == FRAME_LEN-1`.
  - DONE -> IDLE unconditionally after one cycle. `done` = (state == DONE), registered.
- Mismatch on a pop: `err_flag <= 1`, `err_cnt <= err_cnt + 1`. `err_cnt` saturates at 2^CNT_W-1.
- `rd_en` = (state == READ) & `rd_vld`. It is never high in IDLE or DONE, so words left in the FIFO after a frame are not consumed.
- While `rd_vld` is low in READ, nothing advances. There is no timeout.
- `start` in READ or DONE is ignored and not queued.
- `err_flag` and `err_cnt` hold after DONE until the next accepted `start` or reset.
- `idx` width is clog2(FRAME_LEN). The comparison with FRAME_LEN-1 uses that width.

## Timing
- Reset values: state IDLE, `rd_en` 0, `busy` 0, `done` 0, `err_flag` 0, `err_cnt` 0; internal `exp` 0, `idx` 0.
- `start` at edge N: `busy` is high and `rd_en` can assert from cycle N+1.
- A mismatching pop at edge M is visible on `err_flag` / `err_cnt` after edge M.
- Last pop at edge L: `done` is high during cycle L+1, `busy` is low from L+1, and IDLE is reached at L+2. `start` is accepted from L+2.
- Throughput: one word per cycle while `rd_vld` is held high. FRAME_LEN words take at least FRAME_LEN cycles.
- `rd_rst` mid-frame: `rd_en` drops combinationally once state is IDLE (the cycle after the reset edge), and all outputs return to reset values. A partial frame reports nothing.

## Configuration
- `RD_CHECK_ERR_CNT_EN` defined: `err_cnt` counts and saturates as above.
- Not defined: the counter logic is removed and `err_cnt` is tied to 0. `err_flag` and all other behaviour are unchanged.

## Test plan
- FRAME_LEN=8, seed=0x1234, FIFO supplies 0x1234..0x123B with `rd_vld` held high -> eight consecutive `rd_en` cycles; `done` one cycle after the 8th pop; `err_flag`=0, `err_cnt`=0.
- Same frame with word 3 corrupted to 0x0000 -> `err_flag`=1 after the 4th pop and held after `done`; `err_cnt`=1. The next `start` clears both.
- seed=0xFFFE, FRAME_LEN=4, data 0xFFFE, 0xFFFF, 0x0000, 0x0001 -> wrap accepted, `err_cnt`=0.
- `rd_vld` toggling 1,0,0,1,... mid-frame -> `rd_en` only in `rd_vld` cycles; `done` after exactly FRAME_LEN pops. `start` pulsed during READ is ignored.
- `rd_rst` asserted after 3 of 8 pops -> next cycle all outputs are at reset values and no `done`. A fresh `start` checks a full 8-word frame.
- CNT_W=2, all 8 words wrong -> `err_cnt` saturates at 3; `err_flag`=1. With the macro undefined -> `err_cnt`=0, `err_flag`=1.

Source files
------------

// File: rtl/rd_data_check.sv
// Drains one frame from a first-word-fall-through read FIFO and checks it against an incrementing pattern.
// Build option: define RD_CHECK_ERR_CNT_EN to keep the saturating mismatch counter; otherwise err_cnt reads 0.
//
// state  | meaning
// IDLE   | waiting for start; FIFO is never popped
// READ   | popping and comparing one word per valid cycle
// DONE   | one-cycle completion pulse, then back to IDLE
module rd_data_check #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 8192,
    parameter int CNT_W      = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  rd_vld,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err_flag,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] exp_word;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  pop;
    logic                  mismatch;

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                rd_en = rd_vld;
                if (rd_vld && (idx == LAST_IDX)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign pop      = rd_en;
    assign mismatch = pop && (rd_data != exp_word);
    assign busy     = (state == S_READ);
    assign done     = (state == S_DONE);

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state    <= S_IDLE;
            exp_word <= '0;
            idx      <= '0;
            err_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                exp_word <= seed;
                idx      <= '0;
                err_flag <= 1'b0;
            end else if (pop) begin
                exp_word <= exp_word + 1'b1;
                idx      <= idx + 1'b1;
                if (mismatch) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

`ifdef RD_CHECK_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Holds at all-ones once reached so a badly broken frame still reads as "many".
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (mismatch && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
